// File: rtl/shift_rotator_rt_seq.sv
// Sequential 16-bit right shifter/rotator: one bit position per clock, strt/done handshake.
// Supports logical shift, arithmetic shift and rotate right; res holds the result until the next accepted strt.
module shift_rotator_rt_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strt,
  input  logic [WIDTH-1:0] src,
  input  logic [CNT_W-1:0] amt,
  input  logic             rotate,
  input  logic             arith,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             rot_mode;
  logic             arith_mode;
  logic             fill;
  logic [WIDTH-1:0] shifted;

  // Bit entering at the top: the bit leaving bit 0 when rotating, otherwise the sign or a zero.
  // Rotate takes priority over arith.
  always_comb begin
    fill = 1'b0;
    if (rot_mode) begin
      fill = res[0];
    end else if (arith_mode) begin
      fill = res[WIDTH-1];
    end
    shifted = {fill, res[WIDTH-1:1]};
  end

  // A start request is accepted in IDLE and DONE alike, so operations can run back to back.
  // busy and done are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      rot_mode   <= 1'b0;
      arith_mode <= 1'b0;
      res        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (strt) begin
            res        <= src;
            count      <= amt;
            rot_mode   <= rotate;
            arith_mode <= arith;
            if (amt != '0) begin
              state <= SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        SHIFT: begin
          res   <= shifted;
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
